aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Clocked, word-serial AES key schedule for 128-, 192- and 256-bit keys. It expands one cipher key into all round keys, one 32-bit word per cycle, and stores them in an internal round-key buffer. The cipher datapath then reads any round key by index through a registered port. This block replaces per-round combinational expansion, which recomputes a key on every round-number change.

## Interface
- KEY_SIZE, 128, cipher key width; only 128/192/256 are legal, any other value is an elaboration error
- Derived constants: NK = KEY_SIZE/32 (4/6/8), NR = 10/12/14, NW = 4*(NR+1) (44/52/60)
- Reset: one clock; reset is asynchronous and active-high
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request expansion of key_in; sampled on the clk edge
- key_in  input  KEY_SIZE  cipher key; w[0] = key_in[KEY_SIZE-1 -: 32]
- busy  output  1  high while expanding
- done  output  1  one-cycle pulse when the last word is written
- keys_valid  output  1  level; the buffer holds a complete schedule
- rk_idx  input  4  round-key index 0..NR
- rk_out  output  128  registered round key; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits 127:96
- zeroize  input  1  clear request; present only with KEYEXP_ZEROIZE_EN

## Operation
- States: IDLE, EXPAND, READY.
- IDLE or READY with start=1:
  - write w[0..NK-1] from key_in
  - set i=NK, clear keys_valid, go to EXPAND
- EXPAND, each cycle, write w[i] = w[i-NK] ^ t, where t is:
  - SubWord(RotWord(w[i-1])) ^ Rcon[i/NK] when i mod NK == 0
  - SubWord(w[i-1]) when NK == 8 and i mod 8 == 4
  - w[i-1] otherwise
- RotWord rotates left by one byte. The Rcon word is {rc, 24'h0}, with rc = 01,02,04,08,10,20,40,80,1b,36.
- When i == NW-1, the EXPAND cycle also pulses done, sets keys_valid and moves to READY.
- start while in EXPAND is ignored; the expansion already in progress completes unaffected.
- start while in READY restarts expansion. keys_valid drops on that edge.
- busy = (state == EXPAND).
- Read port, every edge:
  - rk_out <= round key rk_idx when keys_valid=1 and rk_idx ≤ NR
  - rk_out <= 0 otherwise, including while expanding
- Arithmetic is XOR only. The index counter is 6 bits wide and never wraps past NW-1.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0, keys_valid 0
  - rk_out 0
  - all buffer words 0
- Reset mid-EXPAND aborts immediately. The buffer is cleared and keys_valid stays 0 until a new complete expansion.
- When start is sampled at edge T:
  - busy=1 from T
  - words NK..NW-1 are written at edges T+1 .. T+(NW-NK)
  - done=1 and keys_valid=1 after edge T+(NW-NK)
- Expansion latency (edges after start): 40 / 46 / 52 for 128 / 192 / 256.
- Read latency is one cycle: rk_idx sampled at edge E appears on rk_out after E.
- done is high for exactly one cycle per completed expansion.

## Configuration
- KEYEXP_ZEROIZE_EN defined:
  - adds the zeroize port
  - zeroize=1 at an edge clears every buffer word, rk_out, done and keys_valid, and forces IDLE within that single edge
  - zeroize has priority over start and over an EXPAND in progress
- KEYEXP_ZEROIZE_EN undefined:
  - the port is absent
  - the buffer is cleared only by rst
  - the buffer otherwise holds its contents until overwritten by a new expansion

## Structure
- Shared package aes_pkg holds:
  - the S-box table
  - the Rcon byte table
  - a function mapping KEY_SIZE to NK/NR/NW
  - the state enum typedef
- One sub-module, key_word_gen, is purely combinational. It takes w[i-1], w[i-NK], i and NK and returns w[i], applying RotWord, SubWord (four S-box lookups) and Rcon.
- The top level holds the FSM, the index counter, the NW×32 buffer and the read register.

## Test plan
- 128-bit, key 2b7e151628aed2a6abf7158809cf4f3c:
  - w[4] = a0fafe17
  - done exactly 40 edges after start
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later
- 192-bit, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w[6] = fe0c91f7
  - w[51] = 01002202
  - done after 46 edges
- 256-bit, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8] = 9ba35411
  - w[59] = 706c631e
  - done after 52 edges
- Pulse start at cycle 10 of an expansion:
  - it is ignored
  - the first key's schedule still completes, with a single done
- Assert rst at cycle 20 of an expansion:
  - all outputs are 0 and keys_valid is 0
  - rk_idx=0 reads 0
  - a fresh start then completes normally
- With KEYEXP_ZEROIZE_EN, assert zeroize in READY:
  - next edge gives keys_valid=0 and rk_out=0 for every rk_idx
  - zeroize asserted together with start leaves the block in IDLE with no expansion started

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the word-serial AES key schedule:
//   - ks_state_t   : key schedule FSM states (IDLE / EXPAND / READY)
//   - ks_params_t  : NK / NR / NW bundle for one key size
//   - SBOX         : AES forward S-box, indexed by input byte
//   - RCON         : round-constant bytes, RCON[0] is used for i/NK == 1
//   - key_params() : maps KEY_SIZE (128/192/256) to its NK / NR / NW
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_READY
   } ks_state_t;

   typedef struct packed {
      logic [3:0] nk;
      logic [3:0] nr;
      logic [5:0] nw;
   } ks_params_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Key-size geometry. Illegal sizes fall back to the 128-bit geometry here;
   // the top level rejects them at elaboration before this value matters.
   function automatic ks_params_t key_params(input int key_size);
      ks_params_t p;
      case (key_size)
         192:     p = '{nk: 4'd6, nr: 4'd12, nw: 6'd52};
         256:     p = '{nk: 4'd8, nr: 4'd14, nw: 6'd60};
         default: p = '{nk: 4'd4, nr: 4'd10, nw: 6'd44};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/key_word_gen.sv
// -----------------------------------------------------------------------------
// key_word_gen
// Purely combinational generator for one expanded key word w[i].
// Ports:
//   w_prev  in  32  w[i-1]
//   w_back  in  32  w[i-NK]
//   idx     in   6  word index i (NK..NW-1)
//   nk      in   4  key length in words (4 / 6 / 8)
//   w_new   out 32  w[i] = w[i-NK] ^ t
// -----------------------------------------------------------------------------
module key_word_gen
   import aes_pkg::*;
(
   input  logic [31:0] w_prev,
   input  logic [31:0] w_back,
   input  logic [5:0]  idx,
   input  logic [3:0]  nk,
   output logic [31:0] w_new
);

   logic [5:0]  nk_ext;
   logic [5:0]  quot;
   logic [5:0]  rem;
   logic [31:0] rot_word;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] t_word;

   // Round constant for a given i/NK; quotients outside 1..10 never occur
   // while expanding, so they simply map to zero.
   function automatic logic [7:0] rcon_byte(input logic [5:0] q);
      if (q >= 6'd1 && q <= 6'd10) begin
         return RCON[4'(q - 6'd1)];
      end
      return 8'h00;
   endfunction

   // The S-box path is shared: its input is the rotated word on the first
   // word of each key block and the plain previous word otherwise, so only
   // four lookups are needed regardless of which transform is selected.
   always_comb begin
      nk_ext   = {2'b00, nk};
      quot     = idx / nk_ext;
      rem      = idx % nk_ext;
      rot_word = {w_prev[23:0], w_prev[31:24]};
      sub_in   = (rem == 6'd0) ? rot_word : w_prev;
      sub_out  = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                  SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
      if (rem == 6'd0) begin
         t_word = sub_out ^ {rcon_byte(quot), 24'h000000};
      end else if (nk == 4'd8 && rem == 6'd4) begin
         t_word = sub_out;
      end else begin
         t_word = w_prev;
      end
      w_new = w_back ^ t_word;
   end

endmodule

// File: rtl/aes_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
// Word-serial AES key expansion (128/192/256-bit keys) into an internal
// round-key buffer, with a registered round-key read port.
// Parameters:
//   KEY_SIZE    128 / 192 / 256; anything else stops elaboration
// Ports:
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous active-high reset
//   start       in   1          begin expansion of key_in (ignored while busy)
//   key_in      in   KEY_SIZE   cipher key, w[0] in the top 32 bits
//   busy        out  1          expansion in progress
//   done        out  1          one-cycle pulse after the last word is written
//   keys_valid  out  1          buffer holds a complete schedule
//   rk_idx      in   4          round key index 0..NR
//   rk_out      out  128        registered round key {w[4r]..w[4r+3]}
//   zeroize     in   1          clear everything (only with KEYEXP_ZEROIZE_EN)
// Build option:
//   KEYEXP_ZEROIZE_EN  adds the zeroize port and its clear behaviour
// -----------------------------------------------------------------------------
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int KEY_SIZE = 128
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_SIZE-1:0] key_in,
   output logic                busy,
   output logic                done,
   output logic                keys_valid,
   input  logic [3:0]          rk_idx,
   output logic [127:0]        rk_out
`ifdef KEYEXP_ZEROIZE_EN
   ,
   input  logic                zeroize
`endif
);

   localparam ks_params_t KP     = key_params(KEY_SIZE);
   localparam int         NK     = int'(KP.nk);
   localparam int         NW     = int'(KP.nw);
   localparam logic [5:0] NK_W   = KP.nk[3:0] == 4'd0 ? 6'd4 : {2'b00, KP.nk};
   localparam logic [5:0] LAST_W = KP.nw - 6'd1;
   localparam logic [3:0] NR_W   = KP.nr;

   generate
      if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
         $error("aes_key_schedule: KEY_SIZE must be 128, 192 or 256");
      end
   endgenerate

   ks_state_t   state_q;
   ks_state_t   state_d;
   logic [5:0]  idx_q;
   logic [31:0] key_words [NW];
   logic        zero_req;
   logic        load;
   logic        last_word;
   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] w_new;
   logic [5:0]  rk_base;

`ifdef KEYEXP_ZEROIZE_EN
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   assign busy    = (state_q == ST_EXPAND);
   assign rk_base = {rk_idx, 2'b00};

   // idx_q never drops below NK, so both look-back reads stay in range
   // even outside EXPAND, where their values are unused.
   assign w_prev = key_words[idx_q - 6'd1];
   assign w_back = key_words[idx_q - NK_W];

   key_word_gen u_word_gen (
      .w_prev (w_prev),
      .w_back (w_back),
      .idx    (idx_q),
      .nk     (KP.nk),
      .w_new  (w_new)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode. start is only honoured outside EXPAND, so a second
   // request mid-expansion cannot disturb the schedule being built. A clear
   // request overrides everything and parks the FSM in IDLE.
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      last_word = 1'b0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (start) begin
               load    = 1'b1;
               state_d = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (idx_q == LAST_W) begin
               last_word = 1'b1;
               state_d   = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (zero_req) begin
         state_d   = ST_IDLE;
         load      = 1'b0;
         last_word = 1'b0;
      end
   end

   // Word counter and status flags. The counter saturates at NW-1 because
   // the FSM leaves EXPAND on the cycle that writes the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q      <= NK_W;
         done       <= 1'b0;
         keys_valid <= 1'b0;
      end else begin
         done <= last_word;
         if (zero_req || load) begin
            idx_q      <= NK_W;
            keys_valid <= 1'b0;
         end else if (last_word) begin
            keys_valid <= 1'b1;
         end else if (state_q == ST_EXPAND) begin
            idx_q <= idx_q + 6'd1;
         end
      end
   end

   // Round-key buffer: the cipher key lands in w[0..NK-1] in one cycle,
   // then one generated word per EXPAND cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NW; j++) begin
            key_words[j] <= '0;
         end
      end else if (zero_req) begin
         for (int j = 0; j < NW; j++) begin
            key_words[j] <= '0;
         end
      end else if (load) begin
         for (int j = 0; j < NK; j++) begin
            key_words[j] <= key_in[KEY_SIZE-1-32*j -: 32];
         end
      end else if (state_q == ST_EXPAND) begin
         key_words[idx_q] <= w_new;
      end
   end

   // Registered read port. Out-of-range indices and an incomplete schedule
   // both read as zero so the cipher never sees a half-built key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rk_out <= '0;
      end else if (zero_req) begin
         rk_out <= '0;
      end else if (keys_valid && rk_idx <= NR_W) begin
         rk_out <= {key_words[rk_base], key_words[rk_base + 6'd1],
                    key_words[rk_base + 6'd2], key_words[rk_base + 6'd3]};
      end else begin
         rk_out <= '0;
      end
   end

endmodule

// File: tb/tb_aes_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_aes_key_schedule
// Self-checking bench for aes_key_schedule. Three instances (128/192/256-bit)
// share clock and reset. The reference model derives the S-box from GF(2^8)
// inversion plus the affine map and runs the textbook key expansion loop.
// Optional: define KEYEXP_ZEROIZE_EN to also exercise the zeroize port.
// -----------------------------------------------------------------------------
module tb_aes_key_schedule;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        start;
   logic [2:0]        busy;
   logic [2:0]        done;
   logic [2:0]        keysValid;
   logic [2:0][255:0] key;
   logic [2:0][3:0]   rkIdx;
   logic [2:0][127:0] rkOut;
`ifdef KEYEXP_ZEROIZE_EN
   logic              zeroize;
`endif

   int          nCompared   = 0;
   int          nMismatched = 0;
   logic [7:0]  sboxRef [256];
   logic [31:0] modelW [3][60];

   typedef struct {
      int          sel;
      logic [255:0] k;
      int          widx;
      logic [31:0] w;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   aes_key_schedule #(.KEY_SIZE(128)) dut128 (
      .clk(clk), .rst(rst), .start(start[0]), .key_in(key[0][255:128]),
      .busy(busy[0]), .done(done[0]), .keys_valid(keysValid[0]),
      .rk_idx(rkIdx[0]), .rk_out(rkOut[0])
`ifdef KEYEXP_ZEROIZE_EN
      , .zeroize(zeroize)
`endif
   );

   aes_key_schedule #(.KEY_SIZE(192)) dut192 (
      .clk(clk), .rst(rst), .start(start[1]), .key_in(key[1][255:64]),
      .busy(busy[1]), .done(done[1]), .keys_valid(keysValid[1]),
      .rk_idx(rkIdx[1]), .rk_out(rkOut[1])
`ifdef KEYEXP_ZEROIZE_EN
      , .zeroize(zeroize)
`endif
   );

   aes_key_schedule #(.KEY_SIZE(256)) dut256 (
      .clk(clk), .rst(rst), .start(start[2]), .key_in(key[2]),
      .busy(busy[2]), .done(done[2]), .keys_valid(keysValid[2]),
      .rk_idx(rkIdx[2]), .rk_out(rkOut[2])
`ifdef KEYEXP_ZEROIZE_EN
      , .zeroize(zeroize)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
   endfunction

   function automatic int nkOf(input int sel);
      return 4 + 2 * sel;
   endfunction

   function automatic int nrOf(input int sel);
      return 10 + 2 * sel;
   endfunction

   task automatic modelExpand(input int sel, input logic [255:0] k);
      int          nk = nkOf(sel);
      int          nw = 4 * (nrOf(sel) + 1);
      logic [7:0]  rc = 8'h01;
      logic [31:0] tmp;
      for (int i = 0; i < 60; i++) modelW[sel][i] = 32'h0;
      for (int i = 0; i < nk; i++) modelW[sel][i] = k[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         tmp = modelW[sel][i-1];
         if (i % nk == 0) begin
            tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % 8 == 4) begin
            tmp = subWord(tmp);
         end
         modelW[sel][i] = modelW[sel][i-nk] ^ tmp;
      end
   endtask

   function automatic logic [127:0] modelRk(input int sel, input int r);
      return {modelW[sel][4*r], modelW[sel][4*r+1], modelW[sel][4*r+2], modelW[sel][4*r+3]};
   endfunction

   // ---------------- stimulus / checking ----------------
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [255:0] k);
      @(negedge clk);
      key[sel]   = k;
      start[sel] = 1'b1;
      @(posedge clk);
      #1;
      start[sel] = 1'b0;
   endtask

   task automatic waitDone(input int sel, input int already, output int edges);
      edges = already;
      while (edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
         if (done[sel]) break;
      end
   endtask

   task automatic readRk(input int sel, input int r, output logic [127:0] val);
      @(negedge clk);
      rkIdx[sel] = 4'(r);
      @(posedge clk);
      #1;
      val = rkOut[sel];
   endtask

   task automatic expandRun(input int sel, input logic [255:0] k, input string tag);
      int edges;
      modelExpand(sel, k);
      applyStimulus(sel, k);
      checkOutput({tag, " busy"}, 128'(busy[sel]), 128'd1);
      waitDone(sel, 0, edges);
      checkOutput({tag, " latency"}, 128'(edges), 128'(4 * (nrOf(sel) + 1) - nkOf(sel)));
      @(posedge clk);
      #1;
      checkOutput({tag, " done width"}, 128'(done[sel]), 128'd0);
      checkOutput({tag, " keys_valid"}, 128'(keysValid[sel]), 128'd1);
   endtask

   task automatic checkAllKeys(input int sel, input string tag);
      logic [127:0] v;
      logic [127:0] exp;
      for (int r = 0; r < 16; r++) begin
         readRk(sel, r, v);
         exp = (r <= nrOf(sel)) ? modelRk(sel, r) : 128'h0;
         checkOutput($sformatf("%s rk[%0d]", tag, r), v, exp);
      end
   endtask

   // Watchdog so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] v;
      logic [255:0] keyA;
      logic [255:0] keyB;
      int           edges;
      int           doneCnt;
      int           firstDone;

      rst   = 1'b1;
      start = '0;
      key   = '0;
      rkIdx = '0;
`ifdef KEYEXP_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      buildSbox();

      vecs[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4,  32'ha0fafe17};
      vecs[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 43, 32'hb6630ca6};
      vecs[2] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 6,  32'hfe0c91f7};
      vecs[3] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 51, 32'h01002202};
      vecs[4] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8,  32'h9ba35411};
      vecs[5] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 59, 32'h706c631e};

      // Reset values on every instance.
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checkOutput($sformatf("reset busy%0d", s), 128'(busy[s]), 128'd0);
         checkOutput($sformatf("reset done%0d", s), 128'(done[s]), 128'd0);
         checkOutput($sformatf("reset kv%0d", s), 128'(keysValid[s]), 128'd0);
         checkOutput($sformatf("reset rk%0d", s), rkOut[s], 128'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Known-answer vectors.
      for (int n = 0; n < 6; n++) begin
         expandRun(vecs[n].sel, vecs[n].k, $sformatf("vec%0d", n));
         readRk(vecs[n].sel, vecs[n].widx / 4, v);
         checkOutput($sformatf("vec%0d w[%0d]", n, vecs[n].widx),
                     128'(v[127-32*(vecs[n].widx % 4) -: 32]), 128'(vecs[n].w));
      end
      readRk(0, 10, v);
      checkOutput("kat128 rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Random keys on every key size, full read-back against the model.
      for (int s = 0; s < 3; s++) begin
         for (int n = 0; n < 3; n++) begin
            keyA = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expandRun(s, keyA, $sformatf("rand%0d_%0d", s, n));
            checkAllKeys(s, $sformatf("rand%0d_%0d", s, n));
         end
      end

      // start pulsed at cycle 10 of an expansion is ignored.
      keyA = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      keyB = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      modelExpand(0, keyA);
      applyStimulus(0, keyA);
      edges     = 0;
      doneCnt   = 0;
      firstDone = 0;
      while (edges < 60) begin
         @(posedge clk);
         edges++;
         #1;
         if (done[0]) begin
            doneCnt++;
            if (firstDone == 0) firstDone = edges;
         end
         start[0] = (edges == 9);
         if (edges == 9) key[0] = keyB;
      end
      checkOutput("ignored start done edge", 128'(firstDone), 128'd40);
      checkOutput("ignored start done count", 128'(doneCnt), 128'd1);
      checkOutput("ignored start busy", 128'(busy[0]), 128'd0);
      checkAllKeys(0, "ignored start");

      // Restart from READY: keys_valid drops on the start edge, reads go to 0.
      keyB = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      modelExpand(0, keyB);
      @(negedge clk);
      rkIdx[0] = 4'd0;
      applyStimulus(0, keyB);
      checkOutput("restart kv drop", 128'(keysValid[0]), 128'd0);
      checkOutput("restart busy", 128'(busy[0]), 128'd1);
      @(posedge clk);
      #1;
      checkOutput("restart rk zero while expanding", rkOut[0], 128'h0);
      waitDone(0, 1, edges);
      checkOutput("restart latency", 128'(edges), 128'd40);
      checkAllKeys(0, "restart");

      // Reset at cycle 20 of an expansion aborts and clears.
      keyA = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      applyStimulus(0, keyA);
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst busy", 128'(busy[0]), 128'd0);
      checkOutput("midrst done", 128'(done[0]), 128'd0);
      checkOutput("midrst kv", 128'(keysValid[0]), 128'd0);
      checkOutput("midrst rk", rkOut[0], 128'h0);
      @(negedge clk);
      rst = 1'b0;
      readRk(0, 0, v);
      checkOutput("midrst rk0 read", v, 128'h0);
      checkOutput("midrst kv after", 128'(keysValid[0]), 128'd0);
      expandRun(0, keyA, "post reset");
      checkAllKeys(0, "post reset");

`ifdef KEYEXP_ZEROIZE_EN
      // Zeroize in READY clears the buffer, flags and read port.
      @(negedge clk);
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("zeroize kv", 128'(keysValid[0]), 128'd0);
      checkOutput("zeroize rk", rkOut[0], 128'h0);
      @(negedge clk);
      zeroize = 1'b0;
      for (int r = 0; r < 16; r++) begin
         readRk(0, r, v);
         checkOutput($sformatf("zeroize rk[%0d]", r), v, 128'h0);
      end
      // Zeroize together with start wins: no expansion begins.
      @(negedge clk);
      zeroize  = 1'b1;
      key[0]   = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      zeroize  = 1'b0;
      start[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("zero+start busy%0d", c), 128'(busy[0]), 128'd0);
         checkOutput($sformatf("zero+start kv%0d", c), 128'(keysValid[0]), 128'd0);
         @(posedge clk);
         #1;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
